// File: rtl/duck_round_ctrl.sv
// duck_round_ctrl
// Round and flight sequencer for the Duck Hunt core. A round is FLIGHTS
// flights. Each flight launches NDUCKS ducks and gives the player SHOTS shots.
// The block tracks shots, hits, the flight index, the round number and the
// game score. It also runs a fly-away timer and applies a per-round pass
// threshold.
//
// Ports
//   Clk, Reset_n   clock, asynchronous active-low reset
//   start          level: start a game from IDLE, or leave OVER back to IDLE
//   frame_tick     one-cycle pulse per video frame (advances the fly-away timer)
//   trigger        one-cycle pulse per gun pull
//   hit[NDUCKS]    per-duck one-cycle hit pulse from hit detect
//   escaped        pulse from sprite logic once every fleeing duck is off-screen
//   phase          0 IDLE, 1 SETUP, 2 FLIGHT, 3 FLEE, 4 TALLY, 5 RND_END, 6 OVER
//                  (also the debug view of the FSM state)
//   duck_active    duck alive and shootable
//   flee           command duck i to fly away
//   flight_start   one-cycle pulse while in SETUP
//   shots_left     remaining shots in this flight
//   flight_idx     current flight, 0-based
//   round_num      current round, 1-based, saturates at MAX_ROUND
//   round_hits     hits scored this round
//   total_hits     game score, saturates at 1023
//   game_over      high while in OVER
//
// Handshake: every input is a single-cycle pulse or a level. There is no
// back-pressure. A pulse is consumed on the edge where it is sampled, and only
// in the phase that uses it. In any other phase the pulse is dropped.
module duck_round_ctrl #(
  parameter int NDUCKS    = 2,
  parameter int SHOTS     = 3,
  parameter int FLIGHTS   = 5,
  parameter int PASS_HITS = 6,
  parameter int MAX_ROUND = 9,
  parameter int FLY_TICKS = 300
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              frame_tick,
  input  logic              trigger,
  input  logic [NDUCKS-1:0] hit,
  input  logic              escaped,
  output logic [2:0]        phase,
  output logic [NDUCKS-1:0] duck_active,
  output logic [NDUCKS-1:0] flee,
  output logic              flight_start,
  output logic [2:0]        shots_left,
  output logic [3:0]        flight_idx,
  output logic [3:0]        round_num,
  output logic [5:0]        round_hits,
  output logic [9:0]        total_hits,
  output logic              game_over
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    FLIGHT  = 3'd2,
    FLEE    = 3'd3,
    TALLY   = 3'd4,
    RND_END = 3'd5,
    OVER    = 3'd6
  } phase_e;

  localparam logic [2:0] SHOTS_V     = 3'(SHOTS);
  localparam logic [3:0] LAST_FLIGHT = 4'(FLIGHTS - 1);
  localparam logic [5:0] PASS_V      = 6'(PASS_HITS);
  localparam logic [3:0] ROUND_MAX   = 4'(MAX_ROUND);
  localparam logic [9:0] FLY_V       = 10'(FLY_TICKS);

  phase_e            state_q, state_d;
  logic [NDUCKS-1:0] active_q, active_d;
  logic [NDUCKS-1:0] flee_q, flee_d;
  logic [2:0]        shots_q, shots_d;
  logic [3:0]        flight_q, flight_d;
  logic [3:0]        round_q, round_d;
  logic [5:0]        rhits_q, rhits_d;
  logic [9:0]        thits_q, thits_d;
  logic [9:0]        timer_q, timer_d;

  // FLIGHT-phase candidate values. The exit decision looks at these
  // post-update values. That lets a final hit taken in the same cycle as
  // the last shot or the timeout end the flight in TALLY instead of FLEE.
  logic [NDUCKS-1:0] hit_eff;
  logic [NDUCKS-1:0] active_upd;
  logic [2:0]        n_hits;
  logic [2:0]        shots_upd;
  logic [5:0]        rhits_upd;
  logic [10:0]       thits_sum;
  logic [9:0]        thits_upd;
  logic [9:0]        timer_upd;

  always_comb begin
    hit_eff    = hit & active_q;
    active_upd = active_q & ~hit;
    n_hits     = '0;
    for (int i = 0; i < NDUCKS; i++) begin
      n_hits = n_hits + {2'b00, hit_eff[i]};
    end
    shots_upd  = (trigger && shots_q != 3'd0) ? shots_q - 3'd1 : shots_q;
    rhits_upd  = rhits_q + {3'b000, n_hits};
    thits_sum  = {1'b0, thits_q} + {8'd0, n_hits};
    thits_upd  = thits_sum[10] ? 10'h3FF : thits_sum[9:0];
    timer_upd  = timer_q + {9'd0, frame_tick};
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    flee_d   = flee_q;
    shots_d  = shots_q;
    flight_d = flight_q;
    round_d  = round_q;
    rhits_d  = rhits_q;
    thits_d  = thits_q;
    timer_d  = timer_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETUP;
          thits_d  = '0;
          rhits_d  = '0;
          round_d  = 4'd1;
          flight_d = '0;
        end
      end
      SETUP: begin
        state_d  = FLIGHT;
        active_d = '1;
        shots_d  = SHOTS_V;
        timer_d  = '0;
        flee_d   = '0;
      end
      FLIGHT: begin
        active_d = active_upd;
        shots_d  = shots_upd;
        rhits_d  = rhits_upd;
        thits_d  = thits_upd;
        timer_d  = timer_upd;
        if (active_upd == '0) begin
          state_d = TALLY;
        end else if (timer_upd >= FLY_V || shots_upd == 3'd0) begin
          state_d = FLEE;
          flee_d  = active_upd;
        end
      end
      FLEE: begin
        if (escaped) begin
          state_d  = TALLY;
          active_d = '0;
          flee_d   = '0;
        end
      end
      TALLY: begin
        if (flight_q == LAST_FLIGHT) begin
          state_d = RND_END;
        end else begin
          state_d  = SETUP;
          flight_d = flight_q + 4'd1;
        end
      end
      RND_END: begin
        if (rhits_q >= PASS_V) begin
          state_d  = SETUP;
          rhits_d  = '0;
          flight_d = '0;
          if (round_q < ROUND_MAX) begin
            round_d = round_q + 4'd1;
          end
        end else begin
          state_d = OVER;
        end
      end
      OVER: begin
        if (start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      active_q <= '0;
      flee_q   <= '0;
      shots_q  <= '0;
      flight_q <= '0;
      round_q  <= 4'd1;
      rhits_q  <= '0;
      thits_q  <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      flee_q   <= flee_d;
      shots_q  <= shots_d;
      flight_q <= flight_d;
      round_q  <= round_d;
      rhits_q  <= rhits_d;
      thits_q  <= thits_d;
      timer_q  <= timer_d;
    end
  end

  assign phase        = state_q;
  assign duck_active  = active_q;
  assign flee         = flee_q;
  assign shots_left   = shots_q;
  assign flight_idx   = flight_q;
  assign round_num    = round_q;
  assign round_hits   = rhits_q;
  assign total_hits   = thits_q;
  assign flight_start = (state_q == SETUP);
  assign game_over    = (state_q == OVER);

endmodule

// File: tb/tb_duck_round_ctrl.sv
// Bench for duck_round_ctrl. The reference model below follows the game
// rules with plain integers and a per-duck alive vector. It is stepped once
// per clock edge, and every output is compared one time unit after the edge.
module tb_duck_round_ctrl;

  localparam int NDUCKS    = 2;
  localparam int SHOTS     = 3;
  localparam int FLIGHTS   = 5;
  localparam int PASS_HITS = 6;
  localparam int MAX_ROUND = 9;
  localparam int FLY_TICKS = 300;

  localparam int P_IDLE = 0, P_SETUP = 1, P_FLIGHT = 2, P_FLEE = 3;
  localparam int P_TALLY = 4, P_RND_END = 5, P_OVER = 6;

  logic              Clk, Reset_n, start, frame_tick, trigger, escaped;
  logic [NDUCKS-1:0] hit;
  logic [2:0]        phase;
  logic [NDUCKS-1:0] duck_active, flee;
  logic              flight_start, game_over;
  logic [2:0]        shots_left;
  logic [3:0]        flight_idx, round_num;
  logic [5:0]        round_hits;
  logic [9:0]        total_hits;

  int total = 0;
  int bad   = 0;

  duck_round_ctrl #(
    .NDUCKS(NDUCKS), .SHOTS(SHOTS), .FLIGHTS(FLIGHTS),
    .PASS_HITS(PASS_HITS), .MAX_ROUND(MAX_ROUND), .FLY_TICKS(FLY_TICKS)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .frame_tick(frame_tick),
    .trigger(trigger), .hit(hit), .escaped(escaped), .phase(phase),
    .duck_active(duck_active), .flee(flee), .flight_start(flight_start),
    .shots_left(shots_left), .flight_idx(flight_idx), .round_num(round_num),
    .round_hits(round_hits), .total_hits(total_hits), .game_over(game_over)
  );

  // clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // reference model state
  int                m_phase, m_shots, m_flight, m_round, m_rhits, m_thits, m_timer;
  logic [NDUCKS-1:0] m_alive, m_flee;

  task automatic model_reset();
    m_phase = P_IDLE; m_shots = 0; m_flight = 0; m_round = 1;
    m_rhits = 0; m_thits = 0; m_timer = 0; m_alive = '0; m_flee = '0;
  endtask

  task automatic model_step(input logic trg, input logic [NDUCKS-1:0] hv,
                            input logic tk, input logic esc, input logic st);
    int n;
    case (m_phase)
      P_IDLE: if (st) begin
        m_phase = P_SETUP; m_thits = 0; m_rhits = 0; m_round = 1; m_flight = 0;
      end
      P_SETUP: begin
        m_phase = P_FLIGHT; m_alive = '1; m_shots = SHOTS; m_timer = 0; m_flee = '0;
      end
      P_FLIGHT: begin
        if (trg && m_shots > 0) m_shots = m_shots - 1;
        n = 0;
        for (int i = 0; i < NDUCKS; i++) begin
          if (hv[i] && m_alive[i]) begin
            m_alive[i] = 1'b0;
            n++;
          end
        end
        m_rhits = m_rhits + n;
        m_thits = (m_thits + n > 1023) ? 1023 : m_thits + n;
        if (tk) m_timer++;
        if (m_alive == '0) m_phase = P_TALLY;
        else if (m_timer >= FLY_TICKS || m_shots == 0) begin
          m_phase = P_FLEE;
          m_flee  = m_alive;
        end
      end
      P_FLEE: if (esc) begin
        m_phase = P_TALLY; m_alive = '0; m_flee = '0;
      end
      P_TALLY: begin
        if (m_flight == FLIGHTS - 1) m_phase = P_RND_END;
        else begin
          m_flight++;
          m_phase = P_SETUP;
        end
      end
      P_RND_END: begin
        if (m_rhits >= PASS_HITS) begin
          if (m_round < MAX_ROUND) m_round++;
          m_rhits = 0; m_flight = 0; m_phase = P_SETUP;
        end else m_phase = P_OVER;
      end
      P_OVER: if (st) m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
  endtask

  // scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("phase",        32'(phase),        32'(m_phase));
    check("duck_active",  32'(duck_active),  32'(m_alive));
    check("flee",         32'(flee),         32'(m_flee));
    check("flight_start", 32'(flight_start), 32'(m_phase == P_SETUP));
    check("shots_left",   32'(shots_left),   32'(m_shots));
    check("flight_idx",   32'(flight_idx),   32'(m_flight));
    check("round_num",    32'(round_num),    32'(m_round));
    check("round_hits",   32'(round_hits),   32'(m_rhits));
    check("total_hits",   32'(total_hits),   32'(m_thits));
    check("game_over",    32'(game_over),    32'(m_phase == P_OVER));
  endtask

  // driver: apply one cycle of inputs, advance the model, compare
  task automatic step(input logic trg, input logic [NDUCKS-1:0] hv,
                      input logic tk, input logic esc, input logic st);
    @(negedge Clk);
    trigger = trg; hit = hv; frame_tick = tk; escaped = esc; start = st;
    @(posedge Clk);
    model_step(trg, hv, tk, esc, st);
    #1 check_all();
  endtask

  task automatic idle_step();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [NDUCKS-1:0] all_ducks;
    logic [NDUCKS-1:0] hv;
    all_ducks = '1;
    trigger = 1'b0; hit = '0; frame_tick = 1'b0; escaped = 1'b0; start = 1'b0;
    Reset_n = 1'b1;
    model_reset();

    // reset state
    #1 Reset_n = 1'b0;
    #1 check_all();
    check("reset_round_num", 32'(round_num), 32'd1);
    @(negedge Clk) Reset_n = 1'b1;

    // flight 0: two shots, two hits -> TALLY with one shot left
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("setup_pulse", 32'(flight_start), 32'd1);
    idle_step();
    check("flight_shots", 32'(shots_left), 32'(SHOTS));
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    check("f0_phase", 32'(phase), 32'(P_TALLY));
    check("f0_shots", 32'(shots_left), 32'd1);
    check("f0_rhits", 32'(round_hits), 32'd2);
    idle_step();
    check("f1_idx", 32'(flight_idx), 32'd1);

    // flight 1: three misses -> FLEE, hits ignored there, escaped -> TALLY
    idle_step();
    repeat (3) step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    check("f1_flee_phase", 32'(phase), 32'(P_FLEE));
    check("f1_flee_vec", 32'(flee), 32'(all_ducks));
    step(1'b1, all_ducks, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("f1_tally", 32'(phase), 32'(P_TALLY));
    check("f1_rhits", 32'(round_hits), 32'd2);

    // flight 2: fly-away timeout exactly on the FLY_TICKS-th tick
    idle_step();
    idle_step();
    repeat (FLY_TICKS - 1) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("f2_before_timeout", 32'(phase), 32'(P_FLIGHT));
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("f2_timeout", 32'(phase), 32'(P_FLEE));
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // flight 3: last shot with a double hit -> TALLY, not FLEE
    idle_step();
    idle_step();
    step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    check("f3_tally", 32'(phase), 32'(P_TALLY));
    check("f3_rhits", 32'(round_hits), 32'd4);

    // flight 4: two more hits -> 6, round passes
    idle_step();
    idle_step();
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    idle_step();
    check("rnd_end", 32'(phase), 32'(P_RND_END));
    idle_step();
    check("r2_num", 32'(round_num), 32'd2);
    check("r2_rhits", 32'(round_hits), 32'd0);

    // round 2: no hits at all -> OVER
    for (int f = 0; f < FLIGHTS; f++) begin
      idle_step();
      repeat (3) step(1'b1, '0, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      idle_step();
    end
    idle_step();
    check("over_flag", 32'(game_over), 32'd1);
    idle_step();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("over_to_idle", 32'(phase), 32'(P_IDLE));
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("restart_total", 32'(total_hits), 32'd0);
    check("restart_round", 32'(round_num), 32'd1);

    // perfect play: round_num saturates at MAX_ROUND, score at 1023
    for (int r = 0; r < 110; r++) begin
      for (int f = 0; f < FLIGHTS; f++) begin
        idle_step();
        step(1'b0, all_ducks, 1'b0, 1'b0, 1'b0);
        idle_step();
      end
      idle_step();
    end
    check("sat_round", 32'(round_num), 32'(MAX_ROUND));
    check("sat_total", 32'(total_hits), 32'd1023);

    // randomized play against the model
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NDUCKS; i++) hv[i] = ($urandom_range(0, 7) == 0);
      step(logic'($urandom_range(0, 3) == 0), hv, logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 31) == 0));
    end

    // steer into FLIGHT, then pulse reset between clock edges
    for (int c = 0; c < 50; c++) begin
      if (m_phase == P_FLIGHT) break;
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    end
    check("reach_flight", 32'(phase), 32'(P_FLIGHT));
    #1;
    trigger = 1'b0; hit = '0; frame_tick = 1'b0; escaped = 1'b0; start = 1'b0;
    Reset_n = 1'b0;
    model_reset();
    #1 check_all();
    check("async_phase", 32'(phase), 32'(P_IDLE));
    check("async_active", 32'(duck_active), 32'd0);
    #1 Reset_n = 1'b1;
    idle_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/duck_round_ctrl.md
# duck_round_ctrl

Parametrised round/flight sequencer for the Duck Hunt core, succeeding the single-bird game control FSM. It runs rounds of FLIGHTS flights, each with NDUCKS simultaneous ducks and SHOTS shots. It owns shot, hit, flight and round bookkeeping, an internal fly-away timer, and a pass/fail threshold per round. It sits between the gun/hit-detect logic and the duck sprite and score-display logic.

## Interface
Parameters:
- NDUCKS, 2: ducks per flight, 1..4.
- SHOTS, 3: shots per flight, 1..7.
- FLIGHTS, 5: flights per round, 2..15.
- PASS_HITS, 6: minimum round hits to advance, 1..NDUCKS*FLIGHTS.
- MAX_ROUND, 9: round counter saturates here, 1..15.
- FLY_TICKS, 300: frame ticks before remaining ducks flee, 2..1023.

Ports:
- Clk, in, 1: system clock.
- Reset_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: level; start game from IDLE, or return to IDLE from OVER.
- frame_tick, in, 1: one-cycle pulse per video frame.
- trigger, in, 1: one-cycle pulse per gun pull.
- hit, in, NDUCKS: per-duck one-cycle hit pulse from hit detect.
- escaped, in, 1: pulse from sprite logic once all fleeing ducks are off-screen.
- phase, out, 3: 0 IDLE, 1 SETUP, 2 FLIGHT, 3 FLEE, 4 TALLY, 5 RND_END, 6 OVER.
- duck_active, out, NDUCKS: duck alive and shootable.
- flee, out, NDUCKS: command duck i to fly away.
- flight_start, out, 1: one-cycle pulse in SETUP.
- shots_left, out, 3: remaining shots.
- flight_idx, out, 4: current flight, 0-based.
- round_num, out, 4: current round, 1-based.
- round_hits, out, 6: hits this round.
- total_hits, out, 10: game score, saturating at 1023.
- game_over, out, 1: high in OVER.

## Operation
- Reset values: phase=IDLE, duck_active=0, flee=0, flight_start=0, shots_left=0, flight_idx=0, round_num=1, round_hits=0, total_hits=0, game_over=0, timer=0.
- IDLE: if start, go to SETUP. On the same edge, clear total_hits and round_hits, set round_num=1 and flight_idx=0.
- SETUP (1 cycle): flight_start=1. On exit, set duck_active to all-ones, shots_left=SHOTS, timer=0, flee=0. Go to FLIGHT.
- FLIGHT:
  - trigger with shots_left>0: decrement shots_left. trigger at 0 is ignored.
  - hit[i] with duck_active[i]=1: clear duck_active[i], increment round_hits and total_hits (saturating). Hits on inactive ducks are ignored. Multiple hit bits in one cycle are each counted.
  - frame_tick: increment timer.
  - Exit priority, evaluated on post-update values:
    - (a) all ducks cleared: go to TALLY.
    - (b) else timer reaches FLY_TICKS, or shots_left reaches 0: go to FLEE and set flee=duck_active.
- FLEE: hits are ignored and duck_active is held. On escaped, clear duck_active and flee, then go to TALLY.
- TALLY (1 cycle):
  - If flight_idx==FLIGHTS-1, go to RND_END.
  - Otherwise increment flight_idx and go to SETUP.
- RND_END (1 cycle):
  - If round_hits>=PASS_HITS: increment round_num (saturating at MAX_ROUND), clear round_hits, set flight_idx=0, go to SETUP.
  - Otherwise go to OVER.
- OVER: game_over=1, all counters hold. On start, go to IDLE. start held high then re-runs IDLE→SETUP on the next edge.
- Reset_n low at any time forces reset values immediately, with no clock needed.

## Timing
- All outputs are registered except flight_start and game_over, which decode phase combinationally.
- trigger/hit at edge N are visible in shots_left/round_hits after edge N. A phase change caused by them is visible after the same edge.
- Last shot together with the final hit in the same cycle: the hit is counted and the flight goes to TALLY, not FLEE.
- Timeout together with the final hit in the same cycle: TALLY.
- Flight latency, minimum: SETUP 1 cycle + FLIGHT ≥1 cycle + TALLY 1 cycle.
- trigger, hit and frame_tick outside FLIGHT: no effect.

## Test plan
- NDUCKS=2, SHOTS=3: after start, hit[0] then hit[1] with 2 triggers → shots_left=1, round_hits=2, TALLY, then SETUP with flight_idx=1.
- Three triggers, no hits → FLEE with flee=2'b11. escaped → TALLY. round_hits unchanged.
- No triggers, FLY_TICKS frame_ticks → FLEE exactly on the FLY_TICKS-th tick.
- Third trigger and hit=2'b11 in the same cycle → round_hits+2, TALLY, no FLEE.
- FLIGHTS=5, PASS_HITS=6:
  - 6 hits → round_num=2, round_hits=0.
  - 5 hits → OVER, game_over=1.
  - start → IDLE → SETUP with total_hits=0, round_num=1.
- Reset_n pulsed low mid-FLIGHT with no clock → all outputs return to reset values asynchronously.
